// File: rtl/cpu_run_ctrl_if.sv
// Command channel between the debug/host side and the run controller.
// The host drives op/arg/valid. The controller answers with ready.
interface cpu_run_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_arg;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_arg,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_arg,
    output cmd_ready
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint controller for the single-cycle CPU.
// It drives global_en from a small FSM and keeps the cycle and retired-instruction counters.
module cpu_run_ctrl #(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned STEP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  cpu_run_ctrl_if.slave     cmd,
  input  logic              commit,
  input  logic [31:0]       commit_pc,
  input  logic              commit_halt,
  output logic              global_en,
  output logic [2:0]        state,
  output logic              bp_hit,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  inst_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_STEP  = 3'd2,
    S_BREAK = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_RUN    = 3'd1,
    OP_STEP   = 3'd2,
    OP_PAUSE  = 3'd3,
    OP_SET_BP = 3'd4,
    OP_CLR_BP = 3'd5,
    OP_CLR_CNT= 3'd6,
    OP_RSVD   = 3'd7
  } op_t;

  state_t              state_q;
  logic                rdy_q;
  logic                bp_valid;
  logic [31:0]         bp_addr;
  logic [STEP_W-1:0]   step_rem;
  logic [STEP_W-1:0]   step_arg;
  op_t                 op;
  logic                acc;
  logic                bp_match;
  logic                idle_or_brk;
  logic                run_or_step;

  assign cmd.cmd_ready = rdy_q;
  assign state         = state_q;
  assign op            = op_t'(cmd.cmd_op);
  assign acc           = cmd.cmd_valid & rdy_q;
  assign step_arg      = cmd.cmd_arg[STEP_W-1:0];
  assign idle_or_brk   = (state_q == S_IDLE) || (state_q == S_BREAK);
  assign run_or_step   = (state_q == S_RUN)  || (state_q == S_STEP);
  // Matching uses the breakpoint registered before this cycle. A SET_BP issued in the same cycle applies to later commits.
  assign bp_match      = (state_q == S_RUN) && commit && bp_valid && (commit_pc == bp_addr);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      global_en <= 1'b0;
      bp_hit    <= 1'b0;
      rdy_q     <= 1'b0;
      bp_valid  <= 1'b0;
      bp_addr   <= '0;
      step_rem  <= '0;
      cycle_cnt <= '0;
      inst_cnt  <= '0;
    end else begin
      rdy_q  <= 1'b1;
      bp_hit <= 1'b0;

      if (acc && op == OP_SET_BP) begin
        bp_addr  <= cmd.cmd_arg;
        bp_valid <= 1'b1;
      end else if (acc && op == OP_CLR_BP) begin
        bp_valid <= 1'b0;
      end

      if (acc && op == OP_CLR_CNT) begin
        cycle_cnt <= '0;
        inst_cnt  <= '0;
      end else begin
        cycle_cnt <= cycle_cnt + CNT_W'(global_en);
        inst_cnt  <= inst_cnt + CNT_W'(commit);
      end

      if (commit && commit_halt) begin
        state_q   <= S_HALT;
        global_en <= 1'b0;
      end else if (bp_match) begin
        state_q   <= S_BREAK;
        global_en <= 1'b0;
        bp_hit    <= 1'b1;
      end else if (acc && op == OP_PAUSE && run_or_step) begin
        state_q   <= S_IDLE;
        global_en <= 1'b0;
      end else if (acc && op == OP_RUN && idle_or_brk) begin
        state_q   <= S_RUN;
        global_en <= 1'b1;
      end else if (acc && op == OP_STEP && idle_or_brk) begin
        state_q   <= S_STEP;
        global_en <= 1'b1;
        step_rem  <= (step_arg == '0) ? STEP_W'(1) : step_arg;
      end else if (state_q == S_STEP) begin
        // step_rem counts the enabled cycles left, including the current one.
        if (step_rem <= STEP_W'(1)) begin
          state_q   <= S_IDLE;
          global_en <= 1'b0;
          step_rem  <= '0;
        end else begin
          step_rem  <= step_rem - STEP_W'(1);
        end
      end
    end
  end

endmodule
